alu_station: RTL

// Reservation station feeding the ALU: the producer end of the station->ALU exec feed.
// - Buffers up to DEPTH renamed ALU instructions from dispatch.
// - Snoops the common data bus (CDB) until both operands are present.
// - Selects one ready entry per cycle into a registered valid/ready exec stage read by the ALU.

---
 rtl/alu_station.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_station.sv
// alu_station: reservation station that feeds the ALU.
//
// Buffers up to DEPTH renamed ALU instructions from dispatch, snoops the
// common data bus until both operands of an entry are present, and issues
// one ready entry per cycle into a registered exec stage read by the ALU.
//
// Ports
//   clk, reset (async, active-high), flush (sync, discards everything)
//   in_*    : dispatch side; in_valid/in_ready handshake
//   cdb_*   : result broadcast snooped for operand wakeup
//   exec_*  : registered exec stage; exec_valid/exec_ready handshake
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A producer holding valid keeps its payload stable until the transfer;
// here that means exec_* do not change while exec_valid && !exec_ready.
//
// Configuration macro: ALU_STATION_OLDEST_FIRST_EN
//   defined   : select the oldest ready entry (per-entry insert-order rank)
//   undefined : select the lowest-index ready entry; no age state

package structures;
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    ADDI = 4'd2,
    ANDI = 4'd3,
    OR   = 4'd4,
    XOR  = 4'd5,
    SLT  = 4'd6,
    SLL  = 4'd7
  } instr_name_e;
endpackage

module alu_station
  import structures::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  instr_name_e          in_instr_name,
  input  logic [XLEN-1:0]      in_address,
  input  logic [XLEN-1:0]      in_immediate,
  input  logic [XLEN-1:0]      in_data_1,
  input  logic [XLEN-1:0]      in_data_2,
  input  logic                 in_src_1_valid,
  input  logic                 in_src_2_valid,
  input  logic [TAG_WIDTH-1:0] in_src_1_tag,
  input  logic [TAG_WIDTH-1:0] in_src_2_tag,
  input  logic [TAG_WIDTH-1:0] in_dest_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic [XLEN-1:0]      cdb_result,
  output logic                 exec_valid,
  input  logic                 exec_ready,
  output instr_name_e          exec_instr_name,
  output logic [XLEN-1:0]      exec_data_1,
  output logic [XLEN-1:0]      exec_data_2,
  output logic [XLEN-1:0]      exec_immediate,
  output logic [XLEN-1:0]      exec_address,
  output logic [TAG_WIDTH-1:0] exec_dest_tag
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    instr_name_e          instr;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      data_1;
    logic [XLEN-1:0]      data_2;
    logic                 src_1_ok;
    logic                 src_2_ok;
    logic [TAG_WIDTH-1:0] tag_1;
    logic [TAG_WIDTH-1:0] tag_2;
    logic [TAG_WIDTH-1:0] dest;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  entry_t           exec_q;
  logic             exec_valid_q;

  logic [DEPTH-1:0] ready_w;
  logic [IW-1:0]    free_idx;
  logic [IW-1:0]    sel_idx;
  logic             sel_found;
  logic             can_issue;
  logic             issue;
  logic             accept;
  entry_t           new_entry;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_w[i] = valid_q[i] & ent_q[i].src_1_ok & ent_q[i].src_2_ok;
    end
  end

  // Built from registered state only, so a slot freed on this edge is not
  // offered until the following cycle.
  assign in_ready = ~&valid_q;

  always_comb begin
    logic found;
    found    = 1'b0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !found) begin
        free_idx = IW'(i);
        found    = 1'b1;
      end
    end
  end

`ifdef ALU_STATION_OLDEST_FIRST_EN
  // age_q is the entry's rank in insert order among valid entries:
  // 0 is the oldest. Ranks stay dense, so the youngest has the highest rank.
  logic [IW-1:0] age_q [DEPTH];
  logic [IW:0]   valid_cnt;
  logic [IW-1:0] new_age;

  always_comb begin
    logic [IW-1:0] best_age;
    best_age  = '1;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_w[i] && (!sel_found || age_q[i] < best_age)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        best_age  = age_q[i];
      end
    end
  end

  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_cnt = valid_cnt + {{IW{1'b0}}, valid_q[i]};
    end
  end

  // The new entry ranks behind everything that survives this edge.
  assign new_age = IW'(valid_cnt - {{IW{1'b0}}, issue});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue && valid_q[i] && age_q[i] > age_q[sel_idx]) begin
          age_q[i] <= age_q[i] - 1'b1;
        end
      end
      if (accept) age_q[free_idx] <= new_age;
    end
  end
`else
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_w[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end
`endif

  assign can_issue = !exec_valid_q || exec_ready;
  assign issue     = can_issue && sel_found;
  assign accept    = in_valid && in_ready;

  // Incoming entry, with same-cycle CDB bypass for unresolved sources.
  always_comb begin
    new_entry          = '0;
    new_entry.instr    = in_instr_name;
    new_entry.addr     = in_address;
    new_entry.imm      = in_immediate;
    new_entry.data_1   = in_data_1;
    new_entry.data_2   = in_data_2;
    new_entry.src_1_ok = in_src_1_valid;
    new_entry.src_2_ok = in_src_2_valid;
    new_entry.tag_1    = in_src_1_tag;
    new_entry.tag_2    = in_src_2_tag;
    new_entry.dest     = in_dest_tag;
    if (cdb_valid && !in_src_1_valid && cdb_tag == in_src_1_tag) begin
      new_entry.src_1_ok = 1'b1;
      new_entry.data_1   = cdb_result;
    end
    if (cdb_valid && !in_src_2_valid && cdb_tag == in_src_2_tag) begin
      new_entry.src_2_ok = 1'b1;
      new_entry.data_2   = cdb_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      exec_valid_q <= 1'b0;
      exec_q       <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (flush) begin
      valid_q      <= '0;
      exec_valid_q <= 1'b0;
    end else begin
      // Wakeup: both sources of one entry may match the same broadcast.
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && cdb_valid) begin
          if (!ent_q[i].src_1_ok && ent_q[i].tag_1 == cdb_tag) begin
            ent_q[i].src_1_ok <= 1'b1;
            ent_q[i].data_1   <= cdb_result;
          end
          if (!ent_q[i].src_2_ok && ent_q[i].tag_2 == cdb_tag) begin
            ent_q[i].src_2_ok <= 1'b1;
            ent_q[i].data_2   <= cdb_result;
          end
        end
      end

      // A selected entry is already fully resolved, so copying the
      // registered entry is unaffected by this cycle's wakeup.
      if (issue) begin
        exec_q           <= ent_q[sel_idx];
        exec_valid_q     <= 1'b1;
        valid_q[sel_idx] <= 1'b0;
      end else if (can_issue) begin
        exec_valid_q <= 1'b0;
      end

      // free_idx is an invalid slot, so it never collides with sel_idx or
      // with a wakeup target.
      if (accept) begin
        ent_q[free_idx]   <= new_entry;
        valid_q[free_idx] <= 1'b1;
      end
    end
  end

  assign exec_valid      = exec_valid_q;
  assign exec_instr_name = exec_q.instr;
  assign exec_data_1     = exec_q.data_1;
  assign exec_data_2     = exec_q.data_2;
  assign exec_immediate  = exec_q.imm;
  assign exec_address    = exec_q.addr;
  assign exec_dest_tag   = exec_q.dest;

endmodule
